video_timing_win: RTL

- Parametrised raster timing generator with one movable rectangular window.
- Produces HS, VS and DE plus pixel coordinates for the DVI transmitter path.
- Produces a per-pixel window request, with in-window column and row offsets, for an image loader.
- Window geometry is runtime-programmable and double-buffered, so a moving image never tears mid-frame.

---
 rtl/video_timing_win.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/video_timing_win.sv
// rtl/video_timing_win.sv - raster timing generator with one double-buffered movable window
// Every output is registered one cycle behind the (h,v) counter state it decodes.
module video_timing_win #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12,
    parameter int FCW      = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic [CW-1:0]  win_x_i,
    input  logic [CW-1:0]  win_y_i,
    input  logic [CW-1:0]  win_w_i,
    input  logic [CW-1:0]  win_h_i,
    output logic           hs_o,
    output logic           vs_o,
    output logic           de_o,
    output logic [CW-1:0]  x_o,
    output logic [CW-1:0]  y_o,
    output logic           win_req_o,
    output logic [CW-1:0]  win_col_o,
    output logic [CW-1:0]  win_row_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic [FCW-1:0] frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]  h_q, h_d, v_q, v_d;
    logic [CW-1:0]  wx_q, wx_d, wy_q, wy_d, ww_q, ww_d, wh_q, wh_d;
    logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic           win_q, win_d;
    logic [CW-1:0]  col_q, col_d, row_q, row_d;
    logic           ls_q, ls_d, fs_q, fs_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    logic           h_last, v_last, de_c, hs_act, vs_act, win_c, load;
    logic [CW:0]    wx_end, wy_end;

    always_comb begin
        h_last = (h_q == H_LAST);
        v_last = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (en_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        de_c   = (h_q < H_ACT) && (v_q < V_ACT);
        hs_act = (h_q >= HS_START) && (h_q < HS_END);
        vs_act = (v_q >= VS_START) && (v_q < VS_END);

        // One extra bit on the far edges so a window hanging past the counter range never wraps.
        wx_end = {1'b0, wx_q} + {1'b0, ww_q};
        wy_end = {1'b0, wy_q} + {1'b0, wh_q};
        win_c  = de_c && (h_q >= wx_q) && ({1'b0, h_q} < wx_end)
                      && (v_q >= wy_q) && ({1'b0, v_q} < wy_end);

        hs_d  = hs_act ? HS_POL : ~HS_POL;
        vs_d  = vs_act ? VS_POL : ~VS_POL;
        de_d  = en_i && de_c;
        win_d = en_i && win_c;
        ls_d  = en_i && (h_q == '0) && (v_q < V_ACT);
        fs_d  = en_i && (h_q == '0) && (v_q == '0);

        x_d    = de_d ? h_q : x_q;
        y_d    = de_d ? v_q : y_q;
        col_d  = win_d ? h_q - wx_q : col_q;
        row_d  = win_d ? v_q - wy_q : row_q;
        fcnt_d = fs_d ? fcnt_q + 1'b1 : fcnt_q;

        // Geometry is only sampled at the last pixel of a frame so a frame never tears.
        load = en_i && h_last && v_last;
        wx_d = load ? win_x_i : wx_q;
        wy_d = load ? win_y_i : wy_q;
        ww_d = load ? win_w_i : ww_q;
        wh_d = load ? win_h_i : wh_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q    <= '0;
            v_q    <= '0;
            wx_q   <= '0;
            wy_q   <= '0;
            ww_q   <= '0;
            wh_q   <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            win_q  <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            fcnt_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            wx_q   <= wx_d;
            wy_q   <= wy_d;
            ww_q   <= ww_d;
            wh_q   <= wh_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            x_q    <= x_d;
            y_q    <= y_d;
            win_q  <= win_d;
            col_q  <= col_d;
            row_q  <= row_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign win_req_o     = win_q;
    assign win_col_o     = col_q;
    assign win_row_o     = row_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;
    assign frame_cnt_o   = fcnt_q;

endmodule
